// File: rtl/hight_arbiter_if.sv
// hight_arbiter_if: requester-side and core-side bundles for the HIGHT arbiter
interface hight_req_if;
  logic         req_val;
  logic         req_rdy;
  logic         req_op;
  logic [127:0] req_key;
  logic         req_key_new;
  logic [63:0]  req_text;
  logic         resp_val;
  logic [63:0]  resp_text;
  modport master (output req_val, req_op, req_key, req_key_new, req_text,
                  input req_rdy, resp_val, resp_text);
  modport slave  (input req_val, req_op, req_key, req_key_new, req_text,
                  output req_rdy, resp_val, resp_text);
endinterface

interface hight_arbiter_if;
  logic         core_mk_rdy;
  logic [127:0] core_mk;
  logic         core_post_rdy;
  logic         core_op;
  logic         core_text_val;
  logic [63:0]  core_text_in;
  logic         core_text_done;
  logic [63:0]  core_text_out;
  logic         core_rdy;
  modport master (output core_mk_rdy, core_mk, core_post_rdy, core_op, core_text_val, core_text_in,
                  input core_text_done, core_text_out, core_rdy);
  modport slave  (input core_mk_rdy, core_mk, core_post_rdy, core_op, core_text_val, core_text_in,
                  output core_text_done, core_text_out, core_rdy);
endinterface

// File: rtl/hight_arbiter.sv
// hight_arbiter: round-robin share of one HIGHT core between two requesters with key caching.
// Optional HIGHT_ARB_STATS_EN adds saturating block/rekey/timeout counters.
module hight_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rstn,
  hight_req_if.slave     req0,
  hight_req_if.slave     req1,
  hight_arbiter_if.master core,
  output logic err
`ifdef HIGHT_ARB_STATS_EN
  ,
  output logic [15:0] stat_blk0,
  output logic [15:0] stat_blk1,
  output logic [15:0] stat_rekey,
  output logic [7:0]  stat_tmo
`endif
);
  typedef enum logic [2:0] {IDLE, KEY, KWAIT, POST, TEXT, TWAIT, RESP} state_t;
  state_t state_q;
  logic rr_q, own_q, kv_q, kown_q, op_q, err_q;
  logic mk_rdy_q, post_q, tval_q, rdy0_q, rdy1_q, rv0_q, rv1_q;
  logic [127:0] key_q;
  logic [63:0] text_q, rt0_q, rt1_q;
  logic [CNT_W-1:0] cnt_q;
  logic gnt_v, gnt, reload, tmo;

  // Grant goes to the requester that did not win last when both are pending
  always_comb begin
    gnt_v  = state_q == IDLE && core.core_rdy && (req0.req_val || req1.req_val);
    gnt    = (req0.req_val && req1.req_val) ? ~rr_q : req1.req_val;
    reload = !kv_q || kown_q != gnt || (gnt ? req1.req_key_new : req0.req_key_new);
    tmo    = cnt_q == CNT_W'(TIMEOUT - 1);
  end

  // Sequencer: accept, optional key load, text phase, response routing
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      rr_q     <= 1'b1;
      own_q    <= 1'b0;
      kv_q     <= 1'b0;
      kown_q   <= 1'b0;
      op_q     <= 1'b0;
      err_q    <= 1'b0;
      mk_rdy_q <= 1'b0;
      post_q   <= 1'b0;
      tval_q   <= 1'b0;
      rdy0_q   <= 1'b0;
      rdy1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      key_q    <= '0;
      text_q   <= '0;
      rt0_q    <= '0;
      rt1_q    <= '0;
      cnt_q    <= '0;
    end else begin
      rdy0_q   <= 1'b0;
      rdy1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      err_q    <= 1'b0;
      mk_rdy_q <= 1'b0;
      post_q   <= 1'b0;
      tval_q   <= 1'b0;
      cnt_q    <= cnt_q + 1'b1;
      case (state_q)
        IDLE: if (gnt_v) begin
          rdy0_q   <= ~gnt;
          rdy1_q   <= gnt;
          own_q    <= gnt;
          rr_q     <= gnt;
          op_q     <= gnt ? req1.req_op : req0.req_op;
          key_q    <= gnt ? req1.req_key : req0.req_key;
          text_q   <= gnt ? req1.req_text : req0.req_text;
          state_q  <= reload ? KEY : TEXT;
          mk_rdy_q <= reload;
          tval_q   <= ~reload;
        end
        KEY: begin
          state_q <= KWAIT;
          cnt_q   <= '0;
        end
        // core_rdy is stale in the first KWAIT cycle, so cnt_q==0 masks it
        KWAIT: if (cnt_q != '0 && core.core_rdy) begin
          state_q <= POST;
          post_q  <= 1'b1;
        end else if (tmo) begin
          err_q   <= 1'b1;
          kv_q    <= 1'b0;
          state_q <= IDLE;
        end
        POST: begin
          kv_q    <= 1'b1;
          kown_q  <= own_q;
          tval_q  <= 1'b1;
          state_q <= TEXT;
        end
        TEXT: begin
          state_q <= TWAIT;
          cnt_q   <= '0;
        end
        TWAIT: if (core.core_text_done) begin
          rv0_q   <= ~own_q;
          rv1_q   <= own_q;
          rt0_q   <= own_q ? rt0_q : core.core_text_out;
          rt1_q   <= own_q ? core.core_text_out : rt1_q;
          state_q <= RESP;
        end else if (tmo) begin
          err_q   <= 1'b1;
          kv_q    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0.req_rdy       = rdy0_q;
  assign req1.req_rdy       = rdy1_q;
  assign req0.resp_val      = rv0_q;
  assign req1.resp_val      = rv1_q;
  assign req0.resp_text     = rt0_q;
  assign req1.resp_text     = rt1_q;
  assign err                = err_q;
  assign core.core_mk_rdy   = mk_rdy_q;
  assign core.core_mk       = key_q;
  assign core.core_post_rdy = post_q;
  assign core.core_op       = op_q;
  assign core.core_text_val = tval_q;
  assign core.core_text_in  = text_q;

`ifdef HIGHT_ARB_STATS_EN
  // Saturating activity counters driven from the registered strobes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_blk0  <= '0;
      stat_blk1  <= '0;
      stat_rekey <= '0;
      stat_tmo   <= '0;
    end else begin
      if (rv0_q && stat_blk0 != '1) stat_blk0 <= stat_blk0 + 1'b1;
      if (rv1_q && stat_blk1 != '1) stat_blk1 <= stat_blk1 + 1'b1;
      if (mk_rdy_q && stat_rekey != '1) stat_rekey <= stat_rekey + 1'b1;
      if (err_q && stat_tmo != '1) stat_tmo <= stat_tmo + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_hight_arbiter.sv
// tb_hight_arbiter: directed test of the HIGHT arbiter against a behavioural core model
module tb_hight_arbiter;
  localparam logic [127:0] K0 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] K1 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic err;
  logic hang = 1'b0;
  int nchk = 0, nfail = 0;
  int cyc = 0, n_mk = 0, n_post = 0, n_err = 0, n_resp = 0, err_cyc = 0, tv_cyc = 0;
  int order[$];

  hight_req_if r0 ();
  hight_req_if r1 ();
  hight_arbiter_if cb ();

`ifdef HIGHT_ARB_STATS_EN
  logic [15:0] s_b0, s_b1, s_rk;
  logic [7:0] s_tmo;
`endif

  hight_arbiter #(.TIMEOUT(255), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .req0(r0), .req1(r1), .core(cb), .err(err)
`ifdef HIGHT_ARB_STATS_EN
    , .stat_blk0(s_b0), .stat_blk1(s_b1), .stat_rekey(s_rk), .stat_tmo(s_tmo)
`endif
  );

  always #5 clk = ~clk;

  // Core model: key schedule drops core_rdy one cycle late, text result after 3 cycles.
  // The result is the known HIGHT vector for K0/zero/encrypt, else a key-dependent XOR.
  logic [127:0] ck;
  logic [63:0] tin;
  logic top, dly;
  int ks, tc;
  function automatic logic [63:0] fcore(input logic [127:0] k, input logic [63:0] t, input logic o);
    if (k == K0 && t == 64'd0 && !o) return 64'h00f418ae_d94f03f2;
    return o ? ~(t ^ k[63:0]) : (t ^ k[63:0]);
  endfunction
  assign cb.core_rdy = (ks == 0);
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ck <= '0; tin <= '0; top <= 1'b0; dly <= 1'b0; ks <= 0; tc <= 0;
      cb.core_text_done <= 1'b0; cb.core_text_out <= '0;
    end else begin
      dly <= cb.core_mk_rdy;
      if (cb.core_mk_rdy) ck <= cb.core_mk;
      ks <= dly ? 3 : (ks > 0 ? ks - 1 : 0);
      cb.core_text_done <= 1'b0;
      if (cb.core_text_val) begin
        tc <= 3; tin <= cb.core_text_in; top <= cb.core_op;
      end else if (tc > 0) begin
        tc <= tc - 1;
        if (tc == 1 && !hang) begin
          cb.core_text_done <= 1'b1;
          cb.core_text_out <= fcore(ck, tin, top);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Event monitor; also checks the three core strobes never overlap
  always @(negedge clk) begin
    cyc++;
    if (cb.core_mk_rdy) n_mk++;
    if (cb.core_post_rdy) n_post++;
    if (cb.core_text_val) tv_cyc = cyc;
    if (err) begin n_err++; err_cyc = cyc; end
    if (r0.resp_val) begin n_resp++; order.push_back(0); end
    if (r1.resp_val) begin n_resp++; order.push_back(1); end
    chk("strobe_onehot", 128'($countones({cb.core_mk_rdy, cb.core_post_rdy, cb.core_text_val}) <= 1), 128'd1);
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(negedge clk); #1; end
  endtask

  task automatic send(input int idx, input logic op, input logic [127:0] k, input logic kn, input logic [63:0] t);
    if (idx == 0) begin
      r0.req_op = op; r0.req_key = k; r0.req_key_new = kn; r0.req_text = t; r0.req_val = 1'b1;
    end else begin
      r1.req_op = op; r1.req_key = k; r1.req_key_new = kn; r1.req_text = t; r1.req_val = 1'b1;
    end
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (idx == 0 && r0.req_rdy) begin r0.req_val = 1'b0; return; end
      if (idx == 1 && r1.req_rdy) begin r1.req_val = 1'b0; return; end
    end
    nchk++; nfail++;
    $error("FAIL accept_timeout: requester %0d never accepted", idx);
    r0.req_val = 1'b0; r1.req_val = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    for (int i = 0; i < 600; i++) begin
      if (n_resp >= target) return;
      tick(1);
    end
    nchk++; nfail++;
    $error("FAIL resp_timeout: observed %0d responses expected %0d", n_resp, target);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(1);
  endtask

  int mk0, post0, err0, rsp0;

  initial begin
    r0.req_val = 0; r0.req_op = 0; r0.req_key = '0; r0.req_key_new = 0; r0.req_text = '0;
    r1.req_val = 0; r1.req_op = 0; r1.req_key = '0; r1.req_key_new = 0; r1.req_text = '0;
    tick(3);
    chk("rst_rdy0", r0.req_rdy, 0);
    chk("rst_resp_val", {r0.resp_val, r1.resp_val, err}, 0);
    chk("rst_core_strobes", {cb.core_mk_rdy, cb.core_post_rdy, cb.core_text_val, cb.core_op}, 0);
    chk("rst_core_mk", cb.core_mk, 0);
    chk("rst_resp_text", {r0.resp_text, r1.resp_text}, 0);
    rstn = 1'b1;
    tick(1);

    // Known-answer block with initial key load
    mk0 = n_mk; post0 = n_post; err0 = n_err; rsp0 = n_resp;
    send(0, 1'b0, K0, 1'b0, 64'd0);
    wait_resp(rsp0 + 1);
    chk("kat_text", r0.resp_text, 64'h00f418ae_d94f03f2);
    chk("kat_mk_once", n_mk - mk0, 1);
    chk("kat_post_once", n_post - post0, 1);
    chk("kat_no_err", n_err - err0, 0);

    // Same owner, same key: no reload; decrypt op routed to core
    mk0 = n_mk; rsp0 = n_resp;
    send(0, 1'b0, K0, 1'b0, 64'h01234567_89abcdef);
    wait_resp(rsp0 + 1);
    chk("cached_text", r0.resp_text, 64'h89baefdc_45762310);
    send(0, 1'b1, K0, 1'b0, 64'd0);
    wait_resp(rsp0 + 2);
    chk("cached_dec_text", r0.resp_text, 64'h77665544_33221100);
    chk("cached_no_mk", n_mk - mk0, 0);

    // Simultaneous requests from reset: req0 first, req1 reloads its own key
    do_reset();
    order.delete();
    mk0 = n_mk; rsp0 = n_resp;
    fork
      send(0, 1'b0, K0, 1'b0, 64'h11111111_11111111);
      send(1, 1'b0, K1, 1'b0, 64'hffffffff_ffffffff);
    join
    wait_resp(rsp0 + 2);
    chk("tie_order", {32'(order.size()), 32'(order[0]), 32'(order[1])}, {32'd2, 32'd0, 32'd1});
    chk("tie_text0", r0.resp_text, 64'h9988bbaa_ddccffee);
    chk("tie_text1", r1.resp_text, 64'hf8f9fafb_fcfdfeff);
    chk("tie_mk_twice", n_mk - mk0, 2);

    // key_new forces a reload for the same owner; next block reuses it
    mk0 = n_mk; rsp0 = n_resp;
    send(1, 1'b0, K1, 1'b1, 64'd0);
    wait_resp(rsp0 + 1);
    chk("keynew_mk", n_mk - mk0, 1);
    chk("keynew_text", r1.resp_text, 64'h07060504_03020100);
    mk0 = n_mk;
    send(1, 1'b1, K1, 1'b0, 64'h07060504_03020100);
    wait_resp(rsp0 + 2);
    chk("keynew_reuse_mk", n_mk - mk0, 0);
    chk("keynew_reuse_text", r1.resp_text, 64'hffffffff_ffffffff);

    // Core never completes: err exactly 256 negedges after the text strobe cycle
    hang = 1'b1;
    err0 = n_err; rsp0 = n_resp;
    send(0, 1'b0, K0, 1'b0, 64'h5);
    for (int i = 0; i < 400 && n_err == err0; i++) tick(1);
    chk("tmo_err_seen", n_err - err0, 1);
    chk("tmo_delay", err_cyc - tv_cyc, 256);
    tick(1);
    chk("tmo_err_pulse", err, 0);
    tick(10);
    chk("tmo_no_resp", n_resp - rsp0, 0);
    hang = 1'b0;
    mk0 = n_mk;
    send(0, 1'b0, K0, 1'b0, 64'd0);
    wait_resp(rsp0 + 1);
    chk("tmo_reload", n_mk - mk0, 1);
    chk("tmo_after_text", r0.resp_text, 64'h00f418ae_d94f03f2);

    // Reset asserted mid-KWAIT: outputs clear without a clock edge, block is dropped
    rsp0 = n_resp;
    send(1, 1'b0, K1, 1'b0, 64'h1234);
    tick(2);
    rstn = 1'b0;
    #1;
    chk("arst_core", {cb.core_mk_rdy, cb.core_post_rdy, cb.core_text_val, cb.core_op, err}, 0);
    chk("arst_core_mk", cb.core_mk, 0);
    chk("arst_resp_text", {r0.resp_text, r1.resp_text}, 0);
    tick(2);
    rstn = 1'b1;
    tick(20);
    chk("arst_no_resp", n_resp - rsp0, 0);
    order.delete();
    mk0 = n_mk; rsp0 = n_resp;
    fork
      send(0, 1'b0, K0, 1'b0, 64'd0);
      send(1, 1'b0, K1, 1'b0, 64'd0);
    join
    wait_resp(rsp0 + 2);
    chk("arst_first_gnt", 32'(order[0]), 0);
    chk("arst_mk", n_mk - mk0, 2);
    chk("arst_text0", r0.resp_text, 64'h00f418ae_d94f03f2);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/hight_arbiter.md
Name: hight_arbiter

Overview:
- Shares one HIGHT block-cipher core between two independent requesters.
- Accepts 64-bit block requests, each carrying its own 128-bit key and an encrypt/decrypt op.
- Reloads the master key only when ownership changes or a requester flags a new key, then sequences the text phase and routes the result back.
- Sits between the crypto clients and the hight instance; it is the only driver of the core's inputs.

Parameters:
- TIMEOUT, 255, max cycles spent waiting on core_rdy or core_text_done before abort.
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req0_val  in  1  requester 0 has a block pending
- req0_rdy  out  1  req0 accepted this cycle (val&rdy)
- req0_op  in  1  0=encrypt, 1=decrypt
- req0_key  in  128  requester 0 master key
- req0_key_new  in  1  force key reload on this request
- req0_text  in  64  input block
- resp0_val  out  1  one-cycle result strobe
- resp0_text  out  64  result block
- req1_* / resp1_*  same set and widths for requester 1
- err  out  1  one-cycle pulse on timeout abort
- core_mk_rdy  out  1  key-load strobe to core
- core_mk  out  128  key to core
- core_post_rdy  out  1  post-key-schedule acknowledge strobe
- core_op  out  1  op to core
- core_text_val  out  1  text strobe to core
- core_text_in  out  64  block to core
- core_text_done  in  1  core result strobe
- core_text_out  in  64  core result
- core_rdy  in  1  core idle / key schedule complete

Behaviour:
- Clock and reset: single clk domain. rstn is asynchronous, active-low.
- Reset values:
  - All outputs 0 and all data outputs 0.
  - State IDLE; key cache invalid; rr pointer=1, so requester 0 wins the first tie.
- Arbitration:
  - Only in IDLE with core_rdy=1.
  - Round-robin; the grant goes to the requester that did not win last when both are valid.
  - reqN_rdy is a one-cycle pulse on acceptance. The requester holds val/op/key/text stable until accepted.
  - op, key, text and owner id are registered at acceptance; inputs are don't-care afterwards.
- Key decision at acceptance:
  - Reload if the cache is invalid, OR cached owner ≠ grantee, OR reqN_key_new=1.
  - Otherwise go straight to TEXT.
- FSM:
  - IDLE -> KEY (reload needed) or TEXT (no reload).
  - KEY: core_mk_rdy=1 for exactly 1 cycle, core_mk=captured key -> KWAIT.
  - KWAIT: wait for core_rdy=1. Ignore core_rdy during the first cycle after the strobe, because the core drops it a cycle late. On core_rdy -> POST.
  - POST: core_post_rdy=1 for 1 cycle; cache valid, owner=grantee -> TEXT.
  - TEXT: core_text_val=1 for 1 cycle with core_op/core_text_in -> TWAIT.
  - TWAIT: on core_text_done, capture core_text_out, pulse respN_val for 1 cycle next cycle with respN_text held until the next response to that requester -> IDLE.
  - Latency acceptance->resp with no reload = 3 + core latency cycles.
- Timeout:
  - Counter clears on entering KWAIT/TWAIT and increments each cycle there.
  - At TIMEOUT: err pulse, cache invalidated, no resp, -> IDLE. rr still advances.
- Stray events:
  - core_text_done outside TWAIT is ignored.
  - No new grant until after the resp cycle; back-to-back requests from one owner are allowed.
- No backpressure on resp. A requester may issue a new req in the same cycle its resp pulses.
- Reset mid-operation: immediate return to reset values; the in-flight block is dropped silently.
- At most one of core_mk_rdy, core_post_rdy, core_text_val is asserted in any cycle.

Optional Feature:
- HIGHT_ARB_STATS_EN defined adds outputs:
  - stat_blk0 [15:0], stat_blk1 [15:0]: completed blocks per requester.
  - stat_rekey [15:0]: key reloads.
  - stat_tmo [7:0]: timeouts.
- All counters saturate, never wrap, and reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Single req0 encrypt, key 0x00112233_44556677_8899aabb_ccddeeff, text 0x00000000_00000000, model core -> core_mk_rdy once, core_post_rdy once, resp0_text=0x00f418ae_d94f03f2, err=0.
- Two req0 blocks, same key, key_new=0 -> second block issues no core_mk_rdy.
- req0 and req1 asserted in the same cycle from reset -> req0 granted first, req1 next, with a key reload before req1's text.
- req1 repeated with key_new=1 -> reload occurs although owner unchanged.
- Core never asserts core_text_done -> err pulse exactly TIMEOUT(255) cycles after entering TWAIT, no resp. The next request reloads the key.
- rstn low during KWAIT -> all outputs 0 asynchronously, no resp after release. First grant after release goes to req0 with a reload.
